// File: rtl/pe_link_packer.sv
// Packs DATA_WIDTH stream words into one registered link flit {valid, last, payload}.
// Optional `PE_LINK_PACKER_PARTIAL_FLUSH_EN: emit short packets zero-padded instead of flagging err_partial.

module pe_link_word_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else if (load)      q <= d;
  end
endmodule

module pe_link_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_FLIT = 4,
  parameter int LINK_WIDTH     = 130,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [LINK_WIDTH-1:0] out_to_east,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic                  err_partial
);
  localparam int IDX_W = (WORDS_PER_FLIT > 1) ? $clog2(WORDS_PER_FLIT) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]                                 state;
  logic [IDX_W-1:0]                           idx, cur_idx;
  logic [WORDS_PER_FLIT-1:0][DATA_WIDTH-1:0]  buf_q, flit_pay;
  logic                                       accept, at_end, terminate, emit;

  assign in_ready  = ap_start;
  assign accept    = in_valid & ap_start;
  assign cur_idx   = (state == IDLE) ? '0 : idx;
  assign at_end    = (cur_idx == IDX_W'(WORDS_PER_FLIT-1));
  // Any packet-ending accept (full flit or early last) empties the buffer.
  assign terminate = accept & (at_end | in_last);

`ifdef PE_LINK_PACKER_PARTIAL_FLUSH_EN
  assign emit        = terminate;
  assign err_partial = 1'b0;
`else
  assign emit = accept & at_end;
  always_ff @(posedge clk) begin
    if (reset)                           err_partial <= 1'b0;
    else if (accept & in_last & ~at_end) err_partial <= 1'b1;
  end
`endif

  // Word being accepted bypasses its slot so the flit leaves on the same edge.
  // Slots past the current index are already zero, which gives the partial-flush padding.
  for (genvar k = 0; k < WORDS_PER_FLIT; k++) begin : g_slot
    pe_link_word_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .clear (terminate),
      .load  (accept & ~terminate & (cur_idx == IDX_W'(k))),
      .d     (in_data),
      .q     (buf_q[k])
    );
    assign flit_pay[k] = (cur_idx == IDX_W'(k)) ? in_data : buf_q[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_to_east <= '0;
      flit_count  <= '0;
      state       <= IDLE;
      idx         <= '0;
    end else begin
      out_to_east <= emit ? {1'b1, in_last, flit_pay} : '0;
      if (emit) flit_count <= flit_count + 1'b1;
      if (terminate) begin
        state <= IDLE;
        idx   <= '0;
      end else if (accept) begin
        state <= FILL;
        idx   <= cur_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pe_link_packer.sv
// Directed + random bench for pe_link_packer against a queue-based packet model.
module tb_pe_link_packer;
  localparam int DW = 32, W = 4, LW = 130, CW = 8;
`ifdef PE_LINK_PACKER_PARTIAL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, ap_start, in_valid, in_last, in_ready, err_partial;
  logic [DW-1:0] in_data;
  logic [LW-1:0] out_to_east;
  logic [CW-1:0] flit_count;

  pe_link_packer #(.DATA_WIDTH(DW), .WORDS_PER_FLIT(W), .LINK_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_to_east(out_to_east),
    .flit_count(flit_count), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DW-1:0] pend[$];
  logic [LW-1:0] exp_out;
  logic [CW-1:0] exp_cnt;
  logic          exp_err;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the packet model, check outputs after the edge.
  task automatic step(input logic r, input logic s, input logic v, input logic [DW-1:0] d, input logic l);
    @(negedge clk);
    reset = r; ap_start = s; in_valid = v; in_data = d; in_last = l;
    #1;
    chk("in_ready", {191'd0, in_ready}, {191'd0, s});
    exp_out = '0;
    if (r) begin
      pend.delete();
      exp_cnt = '0;
      exp_err = 1'b0;
    end else if (s && v) begin
      pend.push_back(d);
      if (pend.size() == W || l) begin
        if (pend.size() == W || FLUSH) begin
          for (int i = 0; i < pend.size(); i++) exp_out[i*DW +: DW] = pend[i];
          exp_out[LW-2] = l;
          exp_out[LW-1] = 1'b1;
          exp_cnt = exp_cnt + 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        pend.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("out_to_east", {62'd0, out_to_east}, {62'd0, exp_out});
    chk("flit_count", {184'd0, flit_count}, {184'd0, exp_cnt});
    chk("err_partial", {191'd0, err_partial}, {191'd0, exp_err});
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    step(1'b0, 1'b1, 1'b1, d, l);
  endtask

  initial begin
    logic [LW-1:0] lit;
    reset = 1'b1; ap_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1);

    // single packet with last on word 3, checked against a literal too
    send(32'h11, 0); send(32'h22, 0); send(32'h33, 0); send(32'h44, 1);
    lit = {1'b1, 1'b1, 32'h44, 32'h33, 32'h22, 32'h11};
    chk("req030_flit", {62'd0, out_to_east}, {62'd0, lit});
    chk("req030_cnt", {184'd0, flit_count}, 192'd1);

    // 8 streaming words, then idle
    for (int i = 0; i < 8; i++) send(32'h100 + i, 0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);

    // ap_start gap mid-packet, in_valid held high so nothing must be taken
    send(32'hA, 0); send(32'hB, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'hBAD0 + i, 1'b0);
    send(32'hC, 0); send(32'hD, 1);
    lit = {1'b1, 1'b1, 32'hD, 32'hC, 32'hB, 32'hA};
    chk("req032_flit", {62'd0, out_to_east}, {62'd0, lit});

    // short packet
    send(32'h1, 0); send(32'h2, 1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);

    // reset mid-packet discards partial words
    send(32'h91, 0); send(32'h92, 0); send(32'h93, 0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    send(32'h5, 0); send(32'h6, 0); send(32'h7, 0); send(32'h8, 0);
    lit = {1'b1, 1'b0, 32'h8, 32'h7, 32'h6, 32'h5};
    chk("req034_flit", {62'd0, out_to_east}, {62'd0, lit});

    // random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 99) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
           $urandom, ($urandom % 6) == 0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // run flit_count up to all-ones, then one more flit wraps it
    while (exp_cnt != {CW{1'b1}})
      for (int i = 0; i < W; i++) send($urandom, i == W-1);
    chk("cnt_all_ones", {184'd0, flit_count}, {184'd0, {CW{1'b1}}});
    for (int i = 0; i < W; i++) send($urandom, 1'b0);
    chk("cnt_wrap", {184'd0, flit_count}, 192'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
